// File: rtl/rf_stream_if.sv
// ============================================================================
// rf_stream_if : register-file port and dump/load stream bundle for
//                rf_stream_ctrl.
// Revision     : 1.0
// ============================================================================
`default_nettype none

interface rf_stream_if #(
  parameter int DATA_W = 32
);
  // Register file ports
  logic [4:0]        rf_raddr_o;
  logic [DATA_W-1:0] rf_rdata_i;
  logic              rf_we_o;
  logic [4:0]        rf_waddr_o;
  logic [DATA_W-1:0] rf_wdata_o;
  // Dump output stream
  logic              dump_valid_o;
  logic              dump_ready_i;
  logic [4:0]        dump_addr_o;
  logic [DATA_W-1:0] dump_data_o;
  // Load input stream
  logic              load_valid_i;
  logic              load_ready_o;
  logic [DATA_W-1:0] load_data_i;

  modport master (
    output rf_raddr_o,
    input  rf_rdata_i,
    output rf_we_o,
    output rf_waddr_o,
    output rf_wdata_o,
    output dump_valid_o,
    input  dump_ready_i,
    output dump_addr_o,
    output dump_data_o,
    input  load_valid_i,
    output load_ready_o,
    input  load_data_i
  );

  modport slave (
    input  rf_raddr_o,
    output rf_rdata_i,
    input  rf_we_o,
    input  rf_waddr_o,
    input  rf_wdata_o,
    input  dump_valid_o,
    output dump_ready_i,
    input  dump_addr_o,
    input  dump_data_o,
    output load_valid_i,
    input  load_ready_o,
    output load_data_i
  );
endinterface

`default_nettype wire

// File: rtl/rf_stream_ctrl.sv
// ============================================================================
// rf_stream_ctrl : dumps x0..x31 as a valid/ready stream and loads x1..x31
//                  from a valid/ready stream through the register-file ports.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module rf_stream_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          dump_req_i,
  input  logic          load_req_i,
  output logic          busy_o,
  output logic          done_o,
  rf_stream_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DUMP = 2'd1,
    S_LOAD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'd31;

  state_t            state_q;
  logic [4:0]        cnt_q;
  logic              rd_done_q;
  logic              busy_q;
  logic              done_q;
  logic              dvalid_q;
  logic [4:0]        daddr_q;
  logic [DATA_W-1:0] ddata_q;
  logic              lready_q;

  logic              beat_accept;
  logic              fill_en;

  assign beat_accept = dvalid_q && bus.dump_ready_i;
  // The output register refills when empty or draining, until all 32 reads are issued.
  assign fill_en     = (!dvalid_q || beat_accept) && !rd_done_q;

  assign bus.rf_raddr_o   = (state_q == S_DUMP) ? cnt_q : 5'd0;
  assign bus.rf_we_o      = (state_q == S_LOAD) && bus.load_valid_i;
  assign bus.rf_waddr_o   = (state_q == S_LOAD) ? cnt_q : 5'd0;
  assign bus.rf_wdata_o   = bus.load_data_i;
  assign bus.dump_valid_o = dvalid_q;
  assign bus.dump_addr_o  = daddr_q;
  assign bus.dump_data_o  = ddata_q;
  assign bus.load_ready_o = lready_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      rd_done_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dvalid_q  <= 1'b0;
      daddr_q   <= 5'd0;
      ddata_q   <= '0;
      lready_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (dump_req_i) begin
            state_q   <= S_DUMP;
            cnt_q     <= 5'd0;
            rd_done_q <= 1'b0;
            busy_q    <= 1'b1;
            dvalid_q  <= 1'b0;
          end else if (load_req_i) begin
            state_q  <= S_LOAD;
            cnt_q    <= 5'd1;
            busy_q   <= 1'b1;
            lready_q <= 1'b1;
          end
        end

        S_DUMP: begin
          if (fill_en) begin
            dvalid_q <= 1'b1;
            daddr_q  <= cnt_q;
            ddata_q  <= (cnt_q == 5'd0) ? '0 : bus.rf_rdata_i;
            if (cnt_q == LAST_IDX) begin
              rd_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end else if (beat_accept) begin
            dvalid_q <= 1'b0;
          end
          if (beat_accept && rd_done_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end

        S_LOAD: begin
          if (bus.load_valid_i) begin
            if (cnt_q == LAST_IDX) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              lready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_stream_ctrl.sv
// ============================================================================
// tb_rf_stream_ctrl : scoreboard bench for rf_stream_ctrl with a behavioural
//                     32x32 register file attached.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_rf_stream_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dump_req = 1'b0;
  logic load_req = 1'b0;
  logic busy, done;
  logic dump_ready = 1'b0;
  logic load_valid = 1'b0;
  logic [31:0] load_data = 32'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_stream_if #(.DATA_W(32)) bus ();

  rf_stream_ctrl #(.DATA_W(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .dump_req_i (dump_req),
    .load_req_i (load_req),
    .busy_o     (busy),
    .done_o     (done),
    .bus        (bus)
  );

  // Register file model and stream stimulus wiring
  logic [31:0] rf [32];
  logic        preload = 1'b0;
  int          wr_cnt = 0;
  int          done_cnt = 0;

  assign bus.rf_rdata_i   = (bus.rf_raddr_o == 5'd0) ? 32'h0 : rf[bus.rf_raddr_o];
  assign bus.dump_ready_i = dump_ready;
  assign bus.load_valid_i = load_valid;
  assign bus.load_data_i  = load_data;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + i;
    end else if (bus.rf_we_o) begin
      rf[bus.rf_waddr_o] <= bus.rf_wdata_o;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected dump beats are queued by the stimulus, popped here
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } beat_t;
  beat_t sb [$];
  logic [31:0] exp_mem [32];

  logic        stalled = 1'b0;
  logic [4:0]  s_addr;
  logic [31:0] s_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        chk("stall_hold", {27'd0, bus.dump_valid_o, bus.dump_addr_o, bus.dump_data_o},
            {27'd0, 1'b1, s_addr, s_data});
      if (bus.dump_valid_o && dump_ready) begin
        if (sb.size() == 0) begin
          chk("dump_extra_beat", {27'd0, bus.dump_addr_o, bus.dump_data_o}, 64'hDEAD);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("dump_beat", {27'd0, bus.dump_addr_o, bus.dump_data_o}, {27'd0, e.a, e.d});
        end
      end
      stalled = bus.dump_valid_o && !dump_ready;
      s_addr  = bus.dump_addr_o;
      s_data  = bus.dump_data_o;
    end
  end

  task automatic run_dump(input bit bp, input bit both_req, input bit busy_req);
    int busy_cycles = 0;
    int cyc = 0;
    int d0 = done_cnt;
    int w0 = wr_cnt;
    for (int n = 0; n < 32; n++) begin
      beat_t b;
      b.a = 5'(n);
      b.d = exp_mem[n];
      sb.push_back(b);
    end
    dump_req = 1'b1;
    load_req = both_req;
    step();
    dump_req = 1'b0;
    load_req = 1'b0;
    while (cyc < 3000) begin
      dump_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      load_req   = busy_req && (cyc == 5);
      @(negedge clk);
      if (!busy) break;
      busy_cycles++;
      step();
      cyc++;
    end
    dump_ready = 1'b0;
    load_req   = 1'b0;
    chk("dump_timeout", 64'(cyc < 3000), 64'd1);
    chk("dump_sb_empty", 64'(sb.size()), 64'd0);
    chk("dump_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("dump_no_writes", 64'(wr_cnt - w0), 64'd0);
    if (!bp) chk("dump_busy_cycles", 64'(busy_cycles), 64'd34);
    sb.delete();
    step();
  endtask

  task automatic run_load(input logic [31:0] base, input int limit);
    int idx = 0;
    int cyc = 0;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    chk("load_ready_up", 64'(bus.load_ready_o), 64'd1);
    while (idx < limit && cyc < 3000) begin
      load_valid = ($urandom_range(0, 9) < 6);
      load_data  = base + 32'(idx + 1);
      @(negedge clk);
      if (load_valid && bus.load_ready_o) begin
        chk("load_waddr", 64'(bus.rf_waddr_o), 64'(idx + 1));
        idx++;
      end
      step();
      cyc++;
    end
    load_valid = 1'b0;
    chk("load_timeout", 64'(cyc < 3000), 64'd1);
  endtask

  initial begin
    int d0, w0;
    exp_mem[0] = 32'h0;
    for (int n = 1; n < 32; n++) exp_mem[n] = 32'h100 + n;

    // Reset check with a preloaded register file
    preload = 1'b1;
    step();
    preload = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dvalid", 64'(bus.dump_valid_o), 64'd0);
    chk("rst_daddr", 64'(bus.dump_addr_o), 64'd0);
    chk("rst_ddata", 64'(bus.dump_data_o), 64'd0);
    chk("rst_lready", 64'(bus.load_ready_o), 64'd0);
    chk("rst_we", 64'(bus.rf_we_o), 64'd0);
    chk("rst_raddr", 64'(bus.rf_raddr_o), 64'd0);
    chk("rst_waddr", 64'(bus.rf_waddr_o), 64'd0);
    load_data = 32'h5A5A_1234;
    #1;
    chk("rst_wdata_pass", 64'(bus.rf_wdata_o), 64'h5A5A_1234);
    chk("rst_no_write", 64'(wr_cnt), 64'd0);
    rst_n = 1'b1;
    step();

    // Dump, ready always high
    run_dump(1'b0, 1'b0, 1'b0);

    // Dump with backpressure
    run_dump(1'b1, 1'b0, 1'b0);

    // Load with gaps, then dump back
    d0 = done_cnt;
    run_load(32'hA000_0000, 31);
    chk("load_done_high", 64'(done), 64'd1);
    step();
    chk("load_done_low", 64'(done), 64'd0);
    chk("load_busy_low", 64'(busy), 64'd0);
    chk("load_done_pulses", 64'(done_cnt - d0), 64'd1);
    for (int n = 1; n < 32; n++) exp_mem[n] = 32'hA000_0000 + n;
    run_dump(1'b0, 1'b0, 1'b0);

    // Simultaneous requests, then load request during dump
    run_dump(1'b0, 1'b1, 1'b0);
    run_dump(1'b1, 1'b0, 1'b1);

    // Reset after 10 accepted load beats
    d0 = done_cnt;
    w0 = wr_cnt;
    run_load(32'hB000_0000, 10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_lready", 64'(bus.load_ready_o), 64'd0);
    chk("midrst_we", 64'(bus.rf_we_o), 64'd0);
    chk("midrst_writes", 64'(wr_cnt - w0), 64'd10);
    rst_n = 1'b1;
    step();
    step();
    chk("midrst_idle", 64'(busy), 64'd0);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    for (int n = 1; n <= 10; n++) exp_mem[n] = 32'hB000_0000 + n;
    run_dump(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/rf_stream_ctrl.md
# rf_stream_ctrl

Sequencer that drives the write and read ports of the 32×32 RISC-V register file from outside the core. It dumps all registers as a valid/ready output stream for debug or testbench inspection, and loads registers x1..x31 from a valid/ready input stream. It sits beside the register file and is muxed onto its ports while the core is held. It issues only register-file port traffic and never touches core state.

## Interface
- DATA_W, 32, register width; all data ports use this width.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low; synchronous deassert is the system's job.
- dump_req_i  in  1  start dump; sampled only in IDLE.
- load_req_i  in  1  start load; sampled only in IDLE; dump_req_i wins if both are high.
- busy_o  out  1  high in DUMP, LOAD, DONE.
- done_o  out  1  one-cycle pulse in DONE.
- rf_raddr_o  out  5  register file read address; read data returns combinationally.
- rf_rdata_i  in  DATA_W  register file read data; x0 reads 0.
- rf_we_o  out  1  register file write enable.
- rf_waddr_o  out  5  register file write address.
- rf_wdata_o  out  DATA_W  register file write data; passthrough of load_data_i.
- dump_valid_o  out  1  output beat valid.
- dump_ready_i  in  1  output beat accepted when valid && ready at a clock edge.
- dump_addr_o  out  5  register index of the current output beat.
- dump_data_o  out  DATA_W  register contents of the current output beat.
- load_valid_i  in  1  input beat valid.
- load_ready_o  out  1  high throughout LOAD.
- load_data_i  in  DATA_W  input beat data.

## Operation
- States:
  - IDLE → DUMP on dump_req_i.
  - IDLE → LOAD on load_req_i, only when dump_req_i is low.
  - DUMP → DONE after beat 31 is accepted.
  - LOAD → DONE after the write to x31.
  - DONE → IDLE unconditionally, after one cycle.
- Requests arriving outside IDLE are ignored; nothing is queued.
- Counter, 5 bits:
  - Set to 0 on entering DUMP; set to 1 on entering LOAD.
  - Never wraps: the terminal values (31) cause the state exit instead of an increment.
- DUMP:
  - rf_raddr_o = counter.
  - One-entry output register holds dump_addr_o, dump_data_o, dump_valid_o.
  - The register loads (rf_rdata_i, counter) when it is empty or its beat is being accepted, and reads remain. Each load increments the counter.
  - 32 beats, addresses 0..31 in order. Beat 0 data is always 0.
  - While dump_valid_o is high and dump_ready_i is low, dump_addr_o and dump_data_o are held stable.
  - dump_valid_o drops after the last beat is accepted.
- LOAD:
  - rf_we_o = (state==LOAD) && load_valid_i.
  - rf_waddr_o = counter; rf_wdata_o = load_data_i.
  - Each accepted beat writes at that clock edge and increments the counter.
  - 31 beats, writing x1..x31. x0 is never written.
- rf_we_o is 0 in every state except LOAD. DUMP never writes.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. Partial loads are not undone; registers already written keep their new values.

## Timing
- Reset values:
  - busy_o=0, done_o=0, dump_valid_o=0, dump_addr_o=0, dump_data_o=0, load_ready_o=0, rf_we_o=0, rf_raddr_o=0, rf_waddr_o=0.
  - rf_wdata_o follows load_data_i.
- Dump, request sampled at edge E:
  - dump_valid_o high after edge E+1 with beat 0.
  - With dump_ready_i held high, beat k is accepted at edge E+2+k, one beat per cycle.
  - Last beat accepted at edge E+33; done_o high during cycle E+33..E+34; busy_o low after edge E+34.
- Load, request sampled at edge E:
  - load_ready_o high after edge E.
  - With load_valid_i held high, x(k) is written at edge E+k for k=1..31.
  - done_o high after edge E+31 for one cycle.
- Backpressure or valid gaps of any length only stretch the timeline; no beat is lost or duplicated.

## Test plan
- Reset check: preload the register file with xN = 0x100+N, assert rst_ni low, release it. Required: all outputs at reset values, no write occurs.
- Dump, ready always high: pulse dump_req_i. Required: 32 consecutive beats (addr N, data 0x100+N, except beat 0 data = 0), then a done_o pulse, busy_o high for exactly 34 cycles.
- Dump with backpressure: random dump_ready_i at 30% duty. Required: data and address stable while stalled, beats in order 0..31, none dropped or repeated.
- Load with gaps: send 31 beats 0xA000_0000+N with random load_valid_i gaps, then dump. Required: xN = 0xA000_0000+N for N=1..31, x0 reads 0.
- Simultaneous and busy requests: assert dump_req_i and load_req_i in the same cycle, then pulse load_req_i during DUMP. Required: a dump runs, rf_we_o never asserts.
- Reset mid-load: assert rst_ni low after 10 accepted beats. Required: x1..x10 updated, x11..x31 unchanged, state IDLE, done_o never pulses.
